fifo_uart_tx: RTL and testbench

- FIFO-draining UART transmitter for the line-echo path.
- Pops bytes from the read side of a first-word-fall-through sync FIFO: head word valid whenever empty is low; one-cycle read strobe pops it.
- Serialises each byte as 8N1, LSB first, on o_uart_tx.
- Frames go back-to-back with no idle gap while the FIFO holds data.

---
 rtl/fifo_uart_tx.sv | 155 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO and serialises each
// byte as 8N1, LSB first, on o_uart_tx. Frames run back-to-back while the
// FIFO holds data. Defining UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
//
// FIFO handshake: i_empty=0 means i_data holds a valid head word. o_rd is
// the pop strobe; a high o_rd on a rising edge consumes the head word and
// that same edge loads it into the shift register. o_rd is only raised
// when the head is valid and the transmitter can accept a byte: idle, or
// in the final cycle of a stop bit.
module fifo_uart_tx #(
    parameter int CLOCKS_PER_BAUD = 217,
    parameter int BW              = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_empty,
    input  logic [BW-1:0] i_data,
    output logic          o_rd,
    output logic          o_uart_tx,
    output logic          o_busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam int IDX_W = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic [IDX_W-1:0] bit_idx, bit_idx_d;
    logic [BW-1:0]    shift_reg, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end   = (baud_cnt == '0);
    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

    // Next-state, pop strobe and next line level; bit timing restarts on every pop.
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        shift_d    = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        o_rd       = i_reset_n && !i_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
        tx_d       = 1'b1;

        if (!bit_end && (state != ST_IDLE)) begin
            baud_cnt_d = baud_cnt - CNT_W'(1);
        end

        case (state)
            ST_START: begin
                if (bit_end) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = CNT_LOAD;
                    bit_idx_d  = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d    = shift_reg >> 1;
                    baud_cnt_d = CNT_LOAD;
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    baud_cnt_d = CNT_LOAD;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A pop always starts a fresh frame, overriding the idle/stop outcome.
        if (o_rd) begin
            state_d    = ST_START;
            baud_cnt_d = CNT_LOAD;
            shift_d    = i_data;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^i_data;
`endif
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State, datapath and registered line/busy outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_cnt_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != ST_IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one instance at 4 clocks/bit, one at 2 clocks/bit,
// each fed by a small FIFO model, checked every cycle against a frame-level
// model and by a line decoder.
module tb_fifo_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int          FB      = 11;
    localparam int          FL4     = 44;
    localparam int          FL2     = 22;
    localparam logic [63:0] LINE_55 = 64'h0F0F0F0F00F;
    localparam int          LINE_N  = 44;
`else
    localparam int          FB      = 10;
    localparam int          FL4     = 40;
    localparam int          FL2     = 20;
    localparam logic [63:0] LINE_55 = 64'h0F0F0F0F0F;
    localparam int          LINE_N  = 40;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] empty_v;
    logic [7:0] data_v [2];
    logic       rd0, tx0, busy0, rd1, tx1, busy1;
    logic [1:0] rd_v, tx_v, busy_v;

    assign rd_v   = {rd1, rd0};
    assign tx_v   = {tx1, tx0};
    assign busy_v = {busy1, busy0};

    fifo_uart_tx #(.CLOCKS_PER_BAUD(4), .BW(8)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_empty(empty_v[0]), .i_data(data_v[0]),
        .o_rd(rd0), .o_uart_tx(tx0), .o_busy(busy0)
    );

    fifo_uart_tx #(.CLOCKS_PER_BAUD(2), .BW(8)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_empty(empty_v[1]), .i_data(data_v[1]),
        .o_rd(rd1), .o_uart_tx(tx1), .o_busy(busy1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // FIFO model storage
    logic [7:0] fmem [2][16];
    int         fhead [2] = '{0, 0};
    int         ftail [2] = '{0, 0};
    bit         pop_pend [2] = '{0, 0};

    // frame model
    bit         m_act [2] = '{0, 0};
    int         m_pos [2] = '{0, 0};
    logic [7:0] m_byte [2];

    // observation
    int         rd_n [2] = '{0, 0};
    int         rd_stamp [2][16];
    int         busy_cnt [2] = '{0, 0};

    // line decoder
    bit         rx_act [2] = '{0, 0};
    int         rx_cnt [2] = '{0, 0};
    logic [7:0] rx_sh [2];
    logic       rx_par [2];
    logic [7:0] rx_mem [2][16];
    int         rx_n [2] = '{0, 0};

    task automatic check(input string name, input int d, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at cycle %0d: got %0h expected %0h",
                     name, d, cyc, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // driver tasks
    task automatic push(input int d, input logic [7:0] b);
        fmem[d][ftail[d] % 16] = b;
        ftail[d]++;
    endtask

    task automatic wait_rx(input int d, input int n, input int budget);
        int k;
        k = 0;
        while (rx_n[d] < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("rx_byte_count", d, 64'(rx_n[d]), 64'(n));
    endtask

    task automatic wait_rd(input int d, input int n, input int budget);
        int k;
        k = 0;
        while (rd_n[d] < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("rd_arrival", d, 64'(rd_n[d]), 64'(n));
    endtask

    // FIFO model, frame model, decoder and per-cycle compare
    initial begin
        int cpb, fl, k;
        logic exp_tx, exp_busy, exp_rd;
        empty_v   = 2'b11;
        data_v[0] = 8'h00;
        data_v[1] = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (pop_pend[d]) begin
                    fhead[d]++;
                    pop_pend[d] = 1'b0;
                end
                empty_v[d] = (fhead[d] == ftail[d]);
                data_v[d]  = empty_v[d] ? 8'h00 : fmem[d][fhead[d] % 16];
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                cpb = (d == 0) ? 4 : 2;
                fl  = FB * cpb;
                if (!rst_n) begin
                    check("rst_rd", d, 64'(rd_v[d]), 64'd0);
                    check("rst_tx", d, 64'(tx_v[d]), 64'd1);
                    check("rst_busy", d, 64'(busy_v[d]), 64'd0);
                    m_act[d]  = 1'b0;
                    rx_act[d] = 1'b0;
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                    if (m_act[d]) begin
                        exp_busy = 1'b1;
                        exp_tx   = frame_bit(m_byte[d], (m_pos[d] - 1) / cpb);
                    end
                    exp_rd = !empty_v[d] && (!m_act[d] || m_pos[d] == fl);
                    check("line", d, 64'(tx_v[d]), 64'(exp_tx));
                    check("busy", d, 64'(busy_v[d]), 64'(exp_busy));
                    check("rd", d, 64'(rd_v[d]), 64'(exp_rd));
                    if (rd_v[d]) begin
                        pop_pend[d] = 1'b1;
                        rd_stamp[d][rd_n[d] % 16] = cyc;
                        rd_n[d]++;
                    end
                    if (exp_rd) begin
                        m_byte[d] = data_v[d];
                        m_act[d]  = 1'b1;
                        m_pos[d]  = 1;
                    end else if (m_act[d]) begin
                        m_pos[d]++;
                        if (m_pos[d] > fl) m_act[d] = 1'b0;
                    end
                    if (busy_v[d]) busy_cnt[d]++;
                    // decoder: mid-bit sampling of the observed line
                    if (!rx_act[d]) begin
                        if (tx_v[d] == 1'b0) begin
                            rx_act[d] = 1'b1;
                            rx_cnt[d] = 0;
                        end
                    end else begin
                        rx_cnt[d]++;
                    end
                    if (rx_act[d] && (rx_cnt[d] % cpb) == cpb / 2) begin
                        k = rx_cnt[d] / cpb;
                        if (k >= 1 && k <= 8) begin
                            rx_sh[d][k-1] = tx_v[d];
                        end else if (k == FB - 1) begin
                            check("stop_bit", d, 64'(tx_v[d]), 64'd1);
                            rx_mem[d][rx_n[d] % 16] = rx_sh[d];
                            rx_n[d]++;
                            rx_act[d] = 1'b0;
                        end else if (k == 9) begin
                            rx_par[d] = tx_v[d];
                        end
                    end
                end
            end
        end
    end

    // directed scenarios
    initial begin
        int x, r, b, s;
        logic [63:0] line_cap;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_tx", 0, 64'(tx0), 64'd1);
        check("reset_busy", 0, 64'(busy0), 64'd0);
        check("reset_rd", 0, 64'(rd0), 64'd0);
        rst_n = 1'b1;

        // idle with empty FIFO
        r = rd_n[0];
        b = busy_cnt[0];
        repeat (200) @(posedge clk);
        check("idle_rd_pulses", 0, 64'(rd_n[0] - r), 64'd0);
        check("idle_busy_cycles", 0, 64'(busy_cnt[0] - b), 64'd0);

        // single byte 0x55
        x = rx_n[0]; r = rd_n[0]; b = busy_cnt[0];
        push(0, 8'h55);
        wait_rd(0, r + 1, 20);
        line_cap = '0;
        for (int i = 0; i < LINE_N; i++) begin
            @(negedge clk);
            #2;
            line_cap = {line_cap[62:0], tx0};
        end
        check("line_55", 0, line_cap, LINE_55);
        wait_rx(0, x + 1, 100);
        repeat (10) @(posedge clk);
        check("byte_55", 0, 64'(rx_mem[0][x % 16]), 64'h55);
        check("pulses_55", 0, 64'(rd_n[0] - r), 64'd1);
        check("busy_55", 0, 64'(busy_cnt[0] - b), 64'(FL4));

        // back-to-back 0x41, 0x42
        x = rx_n[0]; r = rd_n[0]; b = busy_cnt[0];
        push(0, 8'h41);
        push(0, 8'h42);
        wait_rx(0, x + 2, 200);
        repeat (10) @(posedge clk);
        check("byte_41", 0, 64'(rx_mem[0][x % 16]), 64'h41);
        check("byte_42", 0, 64'(rx_mem[0][(x + 1) % 16]), 64'h42);
        check("pulses_4142", 0, 64'(rd_n[0] - r), 64'd2);
        check("rd_spacing", 0, 64'(rd_stamp[0][(r + 1) % 16] - rd_stamp[0][r % 16]), 64'(FL4));
        check("busy_4142", 0, 64'(busy_cnt[0] - b), 64'(2 * FL4));

        // reset in the middle of data bit 3 of 0x00
        r = rd_n[0];
        push(0, 8'h00);
        wait_rd(0, r + 1, 20);
        s = rd_stamp[0][r % 16];
        while (cyc < s + 18) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 0, 64'(tx0), 64'd1);
        check("async_rst_busy", 0, 64'(busy0), 64'd0);
        push(0, 8'hA5);
        repeat (3) @(posedge clk);
        #3;
        x = rx_n[0]; r = rd_n[0];
        rst_n = 1'b1;
        wait_rx(0, x + 1, 100);
        repeat (10) @(posedge clk);
        check("byte_a5", 0, 64'(rx_mem[0][x % 16]), 64'hA5);
        check("pulses_a5", 0, 64'(rd_n[0] - r), 64'd1);

        // two clocks per bit: 0xFF, 0x00, 0x80
        x = rx_n[1]; r = rd_n[1]; b = busy_cnt[1];
        push(1, 8'hFF);
        push(1, 8'h00);
        push(1, 8'h80);
        wait_rx(1, x + 3, 200);
        repeat (10) @(posedge clk);
        check("byte_ff", 1, 64'(rx_mem[1][x % 16]), 64'hFF);
        check("byte_00", 1, 64'(rx_mem[1][(x + 1) % 16]), 64'h00);
        check("byte_80", 1, 64'(rx_mem[1][(x + 2) % 16]), 64'h80);
        check("pulses_3", 1, 64'(rd_n[1] - r), 64'd3);
        check("spacing_a", 1, 64'(rd_stamp[1][(r + 1) % 16] - rd_stamp[1][r % 16]), 64'(FL2));
        check("spacing_b", 1, 64'(rd_stamp[1][(r + 2) % 16] - rd_stamp[1][(r + 1) % 16]), 64'(FL2));
        check("busy_3", 1, 64'(busy_cnt[1] - b), 64'(3 * FL2));

`ifdef UART_TX_PARITY_EN
        // parity bit values
        x = rx_n[0]; b = busy_cnt[0];
        push(0, 8'h07);
        wait_rx(0, x + 1, 100);
        repeat (10) @(posedge clk);
        check("byte_07", 0, 64'(rx_mem[0][x % 16]), 64'h07);
        check("parity_07", 0, 64'(rx_par[0]), 64'd1);
        check("busy_07", 0, 64'(busy_cnt[0] - b), 64'd44);
        x = rx_n[0];
        push(0, 8'h03);
        wait_rx(0, x + 1, 100);
        repeat (10) @(posedge clk);
        check("byte_03", 0, 64'(rx_mem[0][x % 16]), 64'h03);
        check("parity_03", 0, 64'(rx_par[0]), 64'd0);
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
